// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
//
// Two-entry in-order skid buffer sitting in front of an alu32. Decoded ops
// are pushed with their operand values already selected (b = imm or rs2),
// and the head entry drives the ALU's a / b / ALUControl inputs directly.
// in_ready depends only on the registered occupancy, so there is no
// combinational path from out_ready back to in_ready.
//
// Optional feature macro: ALU_ISSUE_FWD_EN
//   defined   : writeback bypass (fwd_valid/fwd_rd/fwd_data) replaces
//               matching operands at push time and patches buffered entries
//               on the same edge; register x0 is never forwarded.
//   undefined : fwd_* inputs are accepted but ignored.
// ---------------------------------------------------------------------------
module alu_issue_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_alusrc,
  input  logic [3:0]      in_ALUControl,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [4:0]      in_rd,

  input  logic            flush,

  input  logic            fwd_valid,
  input  logic [4:0]      fwd_rd,
  input  logic [XLEN-1:0] fwd_data,

  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] a,
  output logic [XLEN-1:0] b,
  output logic [3:0]      ALUControl,
  output logic [4:0]      out_rd
);

  // One buffered op. Source indices are kept only when forwarding needs
  // them to patch operands while the op waits in the buffer.
  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [3:0]      ctl;
    logic [4:0]      rd;
`ifdef ALU_ISSUE_FWD_EN
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            use_rs2;  // b came from rs2 (alusrc = 0)
`endif
  } entry_t;

  entry_t     mem [2];
  logic [1:0] count;
  logic       rd_ptr;
  logic       wr_ptr;
  logic       push;
  logic       pop;
  entry_t     new_entry;

  // Handshake is a pure function of the registered occupancy.
  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

`ifdef ALU_ISSUE_FWD_EN
  logic fwd_live;
  // A bypass from x0 is meaningless: x0 always reads as zero.
  assign fwd_live = fwd_valid && (fwd_rd != 5'd0);
`else
  logic fwd_unused;
  // Bypass inputs and source indices have no function in this build.
  assign fwd_unused = ^{fwd_valid, fwd_rd, fwd_data, in_rs1, in_rs2};
`endif

  // Assemble the entry to be written on a push, selecting b and applying
  // any same-cycle bypass.
  always_comb begin
    // NOTE: every field gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    new_entry     = '0;
    new_entry.a   = in_rs1_data;
    new_entry.b   = in_alusrc ? in_imm : in_rs2_data;
    new_entry.ctl = in_ALUControl;
    new_entry.rd  = in_rd;
`ifdef ALU_ISSUE_FWD_EN
    new_entry.rs1     = in_rs1;
    new_entry.rs2     = in_rs2;
    new_entry.use_rs2 = !in_alusrc;
    if (fwd_live && (fwd_rd == in_rs1)) begin
      new_entry.a = fwd_data;
    end
    if (fwd_live && !in_alusrc && (fwd_rd == in_rs2)) begin
      new_entry.b = fwd_data;
    end
`endif
  end

  // Occupancy and pointers; rst beats flush, flush beats push/pop.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else if (flush) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage: bypass patching of waiting ops, then the push write.
  always_ff @(posedge clk) begin
    // NOTE: the data array carries no reset; occupancy alone decides which
    // entries are meaningful, and outputs are masked when nothing is valid.
`ifdef ALU_ISSUE_FWD_EN
    for (int i = 0; i < 2; i++) begin
      if (fwd_live && (mem[i].rs1 == fwd_rd)) begin
        mem[i].a <= fwd_data;
      end
      if (fwd_live && mem[i].use_rs2 && (mem[i].rs2 == fwd_rd)) begin
        mem[i].b <= fwd_data;
      end
    end
`endif
    // The write slot is never a live entry (push needs count < 2), so a
    // push never collides with a patch of a buffered op.
    if (push) begin
      mem[wr_ptr] <= new_entry;
    end
  end

  // Present the head entry, forced to zero while the buffer is empty.
  always_comb begin
    a          = '0;
    b          = '0;
    ALUControl = '0;
    out_rd     = '0;
    if (out_valid) begin
      a          = mem[rd_ptr].a;
      b          = mem[rd_ptr].b;
      ALUControl = mem[rd_ptr].ctl;
      out_rd     = mem[rd_ptr].rd;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_stage
//
// Directed bench for alu_issue_stage. Inputs change 1 time unit after the
// rising edge and outputs are checked at that same point, i.e. showing the
// state the edge just produced. Forwarding expectations follow whether
// ALU_ISSUE_FWD_EN is defined for the build.
// ---------------------------------------------------------------------------
module tb_alu_issue_stage;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_rs1_data;
  logic [XLEN-1:0] in_rs2_data;
  logic [XLEN-1:0] in_imm;
  logic            in_alusrc;
  logic [3:0]      in_ALUControl;
  logic [4:0]      in_rs1;
  logic [4:0]      in_rs2;
  logic [4:0]      in_rd;
  logic            flush;
  logic            fwd_valid;
  logic [4:0]      fwd_rd;
  logic [XLEN-1:0] fwd_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [3:0]      ALUControl;
  logic [4:0]      out_rd;

  int total = 0;
  int bad   = 0;

`ifdef ALU_ISSUE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  alu_issue_stage #(.XLEN(XLEN)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_rs1_data   (in_rs1_data),
    .in_rs2_data   (in_rs2_data),
    .in_imm        (in_imm),
    .in_alusrc     (in_alusrc),
    .in_ALUControl (in_ALUControl),
    .in_rs1        (in_rs1),
    .in_rs2        (in_rs2),
    .in_rd         (in_rd),
    .flush         (flush),
    .fwd_valid     (fwd_valid),
    .fwd_rd        (fwd_rd),
    .fwd_data      (fwd_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .a             (a),
    .b             (b),
    .ALUControl    (ALUControl),
    .out_rd        (out_rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full view of the ALU-side outputs plus in_ready.
  task automatic check_out(input string tag, input logic v, input logic rdy,
                           input logic [31:0] ea, input logic [31:0] eb,
                           input logic [3:0] ectl, input logic [4:0] erd);
    check({tag, ".out_valid"}, 64'(out_valid), 64'(v));
    check({tag, ".in_ready"}, 64'(in_ready), 64'(rdy));
    check({tag, ".a"}, 64'(a), 64'(ea));
    check({tag, ".b"}, 64'(b), 64'(eb));
    check({tag, ".ctl"}, 64'(ALUControl), 64'(ectl));
    check({tag, ".rd"}, 64'(out_rd), 64'(erd));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                        input logic src, input logic [3:0] ctl,
                        input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
    in_valid      = 1'b1;
    in_rs1_data   = d1;
    in_rs2_data   = d2;
    in_imm        = imm;
    in_alusrc     = src;
    in_ALUControl = ctl;
    in_rs1        = r1;
    in_rs2        = r2;
    in_rd         = rd;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_rs1_data = '0; in_rs2_data = '0; in_imm = '0; in_alusrc = 1'b0;
    in_ALUControl = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    fwd_valid = 1'b0; fwd_rd = '0; fwd_data = '0;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    check_out("reset", 1'b0, 1'b1, 32'd0, 32'd0, 4'd0, 5'd0);

    // Single op: visible the cycle after push, never the same cycle
    set_op(32'd10, 32'd10, 32'd0, 1'b0, 4'b0000, 5'd1, 5'd2, 5'd4);
    #1;
    check("no_passthrough.out_valid", 64'(out_valid), 64'd0);
    tick();
    in_valid = 1'b0;
    check_out("single.head", 1'b1, 1'b1, 32'd10, 32'd10, 4'b0000, 5'd4);
    tick();
    check_out("single.drained", 1'b0, 1'b1, 32'd0, 32'd0, 4'd0, 5'd0);

    // Back-to-back pushes against a stalled consumer
    out_ready = 1'b0;
    set_op(32'd1, 32'd2, 32'd0, 1'b0, 4'b0001, 5'd1, 5'd2, 5'd3);
    tick();
    check_out("fill1", 1'b1, 1'b1, 32'd1, 32'd2, 4'b0001, 5'd3);
    set_op(32'd4, 32'd5, 32'd0, 1'b0, 4'b0010, 5'd4, 5'd5, 5'd6);
    tick();
    check_out("fill2", 1'b1, 1'b0, 32'd1, 32'd2, 4'b0001, 5'd3);
    set_op(32'd7, 32'd8, 32'd0, 1'b0, 4'b0011, 5'd7, 5'd8, 5'd9);
    tick();
    check_out("held3", 1'b1, 1'b0, 32'd1, 32'd2, 4'b0001, 5'd3);
    out_ready = 1'b1;
    tick();
    // Third op still offered: this cycle pushes and pops together
    check_out("drain2", 1'b1, 1'b1, 32'd4, 32'd5, 4'b0010, 5'd6);
    tick();
    in_valid = 1'b0;
    check_out("drain3", 1'b1, 1'b1, 32'd7, 32'd8, 4'b0011, 5'd9);
    tick();
    check_out("drain_empty", 1'b0, 1'b1, 32'd0, 32'd0, 4'd0, 5'd0);

    // Immediate operand selects imm over rs2_data
    out_ready = 1'b0;
    set_op(32'd3, 32'd10, 32'hFFFF_FFF6, 1'b1, 4'b0100, 5'd1, 5'd2, 5'd5);
    tick();
    check_out("imm", 1'b1, 1'b1, 32'd3, 32'hFFFF_FFF6, 4'b0100, 5'd5);

    // Flush at count 2 with a push offered
    set_op(32'd11, 32'd12, 32'd0, 1'b0, 4'b0101, 5'd1, 5'd2, 5'd6);
    tick();
    check("full.in_ready", 64'(in_ready), 64'd0);
    set_op(32'd13, 32'd14, 32'd0, 1'b0, 4'b0110, 5'd1, 5'd2, 5'd7);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check_out("flush_full", 1'b0, 1'b1, 32'd0, 32'd0, 4'd0, 5'd0);
    tick();
    check("flush_full.absent", 64'(out_valid), 64'd0);

    // Flush beats a push and pop at count 1
    set_op(32'd15, 32'd16, 32'd0, 1'b0, 4'b0111, 5'd1, 5'd2, 5'd8);
    tick();
    out_ready = 1'b1; flush = 1'b1;
    set_op(32'd17, 32'd18, 32'd0, 1'b0, 4'b1000, 5'd1, 5'd2, 5'd9);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check_out("flush_pushpop", 1'b0, 1'b1, 32'd0, 32'd0, 4'd0, 5'd0);

    // Bypass patching of a buffered rs1 operand
    out_ready = 1'b0;
    set_op(32'd10, 32'd20, 32'd0, 1'b0, 4'b0111, 5'd5, 5'd6, 5'd2);
    tick();
    in_valid = 1'b0;
    fwd_valid = 1'b1; fwd_rd = 5'd5; fwd_data = 32'h55;
    tick();
    fwd_valid = 1'b0;
    check_out("fwd_rs1", 1'b1, 1'b1, FWD ? 32'h55 : 32'd10, 32'd20, 4'b0111, 5'd2);
    fwd_valid = 1'b1; fwd_rd = 5'd6; fwd_data = 32'h77;
    tick();
    fwd_valid = 1'b0;
    check("fwd_rs2.b", 64'(b), FWD ? 64'h77 : 64'd20);

    // x0 is never forwarded
    flush = 1'b1;
    tick();
    flush = 1'b0;
    set_op(32'd10, 32'd20, 32'd0, 1'b0, 4'b0001, 5'd0, 5'd0, 5'd1);
    tick();
    in_valid = 1'b0;
    fwd_valid = 1'b1; fwd_rd = 5'd0; fwd_data = 32'h66;
    tick();
    fwd_valid = 1'b0;
    check("fwd_x0.a", 64'(a), 64'd10);
    check("fwd_x0.b", 64'(b), 64'd20);

    // Bypass at push time; imm operand is never replaced
    flush = 1'b1;
    tick();
    flush = 1'b0;
    set_op(32'd1, 32'd2, 32'd0, 1'b0, 4'b0010, 5'd3, 5'd9, 5'd1);
    fwd_valid = 1'b1; fwd_rd = 5'd9; fwd_data = 32'h99;
    tick();
    set_op(32'd4, 32'd5, 32'h123, 1'b1, 4'b0011, 5'd8, 5'd9, 5'd2);
    tick();
    in_valid = 1'b0; fwd_valid = 1'b0;
    check("fwd_push.a", 64'(a), 64'd1);
    check("fwd_push.b", 64'(b), FWD ? 64'h99 : 64'd2);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("fwd_imm.b", 64'(b), 64'h123);
    check("fwd_imm.a", 64'(a), 64'd4);

    // Reset with two ops buffered, flush low
    set_op(32'd21, 32'd22, 32'd0, 1'b0, 4'b1001, 5'd1, 5'd2, 5'd3);
    tick();
    in_valid = 1'b0;
    check("pre_rst.in_ready", 64'(in_ready), 64'd0);
    rst = 1'b1;
    set_op(32'd23, 32'd24, 32'd0, 1'b0, 4'b1010, 5'd1, 5'd2, 5'd4);
    tick();
    rst = 1'b0; in_valid = 1'b0;
    check_out("rst_full", 1'b0, 1'b1, 32'd0, 32'd0, 4'd0, 5'd0);
    tick();
    check("rst_full.absent", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 SHALL have parameter: XLEN, 32, operand/result data width.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports: in_valid input 1, decoded op offered; in_ready output 1, stage can accept.
REQ-005 SHALL have ports: in_rs1_data input XLEN, source 1 value; in_rs2_data input XLEN, source 2 value; in_imm input XLEN, sign-extended immediate.
REQ-006 SHALL have ports: in_alusrc input 1 (1 = b takes imm); in_ALUControl input 4, ALU opcode; in_rs1, in_rs2, in_rd input 5 each, register indices.
REQ-007 SHALL have port: flush  input  1  discard all buffered ops.
REQ-008 SHALL have ports: fwd_valid input 1, fwd_rd input 5, fwd_data input XLEN: writeback bypass source.
REQ-009 SHALL have ports: out_valid output 1, head op valid; out_ready input 1, ALU side consumes.
REQ-010 SHALL have ports: a output XLEN, b output XLEN, ALUControl output 4, out_rd output 5: head op fields driving alu32 a/b/ALUControl.

Function
REQ-011 SHALL hold ops in a 2-entry in-order FIFO (skid buffer); count range 0..2.
REQ-012 SHALL assert in_ready iff count < 2, derived from registered count only (no combinational path from out_ready).
REQ-013 SHALL push on a cycle with in_valid && in_ready; SHALL pop on a cycle with out_valid && out_ready.
REQ-014 SHALL assert out_valid iff count > 0; a/b/ALUControl/out_rd SHALL show the head entry, and SHALL be 0 when out_valid = 0.
REQ-015 SHALL compute stored b at push: in_alusrc ? in_imm : in_rs2_data; stored a = in_rs1_data.
REQ-016 Simultaneous push and pop: count unchanged; at count 1 the pushed op becomes head next cycle.
REQ-017 Empty-to-valid latency: op pushed in cycle N SHALL appear with out_valid in cycle N+1; no same-cycle pass-through.
REQ-018 Ordering SHALL be strict FIFO; no op dropped or duplicated except by flush/rst.
REQ-019 flush SHALL set count to 0 next cycle and win over a simultaneous push or pop (pushed op discarded).
REQ-020 Held outputs SHALL stay stable while out_valid && !out_ready, except patching under REQ-024.

Reset
REQ-021 On rst sampled high: count = 0, out_valid = 0, in_ready = 1 next cycle, a = b = 0, ALUControl = 0, out_rd = 0.
REQ-022 rst mid-operation SHALL discard all buffered ops, with priority over flush, push and pop.
REQ-023 Storage data contents need not reset; only count/pointers/valid.

Configuration
REQ-024 Macro ALU_ISSUE_FWD_EN defined: at push, if fwd_valid && fwd_rd != 0 && fwd_rd == in_rs1, stored a = fwd_data; same for in_rs2 when in_alusrc = 0 (b = fwd_data); buffered entries with matching rs1 (or rs2 with alusrc = 0) SHALL be patched in the same edge; x0 never forwarded.
REQ-025 Macro ALU_ISSUE_FWD_EN undefined: fwd_* ports present but ignored; operands are exactly the pushed values.

Verification
REQ-026 rst, then push rs1_data=10, rs2_data=10, alusrc=0, ALUControl=0000, out_ready=1 -> cycle+1 out_valid=1, a=10, b=10, ALUControl=0000; cycle+2 out_valid=0, outputs 0.
REQ-027 out_ready=0, push 3 ops (ALUControl 0001,0010,0011) back-to-back -> in_ready low after 2nd; 3rd held; out_ready=1 -> outputs 0001,0010,0011 in order, no loss.
REQ-028 alusrc=1, imm=0xFFFFFFF6, rs2_data=10 -> b=0xFFFFFFF6.
REQ-029 count=2, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, pushed op absent.
REQ-030 ALU_ISSUE_FWD_EN on: rs1=5 buffered with a=10, out_ready=0, fwd_valid=1, fwd_rd=5, fwd_data=0x55 -> a=0x55; repeat with fwd_rd=0 -> a unchanged; macro off -> a=10.
REQ-031 rst asserted with count=2 and flush=0 -> next cycle count=0, out_valid=0, all outputs 0.
